// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage operand/control fields and branch resolution in,
// stall/flush/bubble enables, forwarding selects and perf counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  branch_taken_mem;

  logic                  pc_write_en;
  logic                  if_id_write_en;
  logic                  id_ex_bubble;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  flush_ex_mem;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, branch_taken_mem,
    input  pc_write_en, if_id_write_en, id_ex_bubble, flush_if_id, flush_id_ex,
           flush_ex_mem, fwd_a, fwd_b, stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, branch_taken_mem,
    output pc_write_en, if_id_write_en, id_ex_bubble, flush_if_id, flush_id_ex,
           flush_ex_mem, fwd_a, fwd_b, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage RV32I hazard unit: load-use stall, taken-branch flush, EX operand forwarding.
// Stall/flush/forward are combinational; shadows advance each CLK. Optional counters: HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic                 CLK,
  input logic                 RESET_N,
  pipeline_hazard_ctrl_if.slave hz
);

  logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic                  ex_rw, ex_mr, ex_valid;
  logic                  mem_rw, mem_valid;
  logic                  wb_rw, wb_valid;

  logic load_use, branch, stall;
  logic fwd_mem_a, fwd_wb_a, fwd_mem_b, fwd_wb_b;

  assign load_use = ex_valid & ex_mr & (ex_rd != '0) & hz.id_valid &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == ex_rd)));

  // Reset masks the branch input so no flush is visible while RESET_N is low.
  assign branch = RESET_N & hz.branch_taken_mem;
  assign stall  = load_use & ~branch;

  assign hz.pc_write_en    = ~stall;
  assign hz.if_id_write_en = ~stall;
  assign hz.id_ex_bubble   = stall;
  assign hz.flush_if_id    = branch;
  assign hz.flush_id_ex    = branch;
  assign hz.flush_ex_mem   = branch;

  assign fwd_mem_a = mem_valid & mem_rw & (mem_rd != '0) & (mem_rd == ex_rs1);
  assign fwd_wb_a  = wb_valid  & wb_rw  & (wb_rd  != '0) & (wb_rd  == ex_rs1);
  assign fwd_mem_b = mem_valid & mem_rw & (mem_rd != '0) & (mem_rd == ex_rs2);
  assign fwd_wb_b  = wb_valid  & wb_rw  & (wb_rd  != '0) & (wb_rd  == ex_rs2);

  assign hz.fwd_a = fwd_mem_a ? 2'b10 : (fwd_wb_a ? 2'b01 : 2'b00);
  assign hz.fwd_b = fwd_mem_b ? 2'b10 : (fwd_wb_b ? 2'b01 : 2'b00);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_valid  <= 1'b0;
      mem_rd    <= '0;
      mem_rw    <= 1'b0;
      mem_valid <= 1'b0;
      wb_rd     <= '0;
      wb_rw     <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      // Register fields always follow ID; only the valid/control bits are killed.
      ex_rd     <= hz.id_rd;
      ex_rs1    <= hz.id_rs1;
      ex_rs2    <= hz.id_rs2;
      ex_valid  <= hz.id_valid & ~(stall | branch);
      ex_rw     <= hz.id_valid & hz.id_reg_write & ~(stall | branch);
      ex_mr     <= hz.id_valid & hz.id_mem_read & ~(stall | branch);
      mem_rd    <= ex_rd;
      mem_valid <= ex_valid & ~branch;
      mem_rw    <= ex_valid & ex_rw & ~branch;
      wb_rd     <= mem_rd;
      wb_valid  <= mem_valid;
      wb_rw     <= mem_valid & mem_rw;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_events = '0;
`endif

endmodule
